// File: rtl/riscv_loader_pkg.sv
// rtl/riscv_loader_pkg.sv - shared FSM state type and word-size constant for the memory loader
package riscv_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/riscv_mem_loader_if.sv
// rtl/riscv_mem_loader_if.sv - valid/ready word stream feeding the memory loader
interface riscv_mem_loader_if #(
  parameter int DATA_W = 32
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/riscv_loader_hold_cnt.sv
// rtl/riscv_loader_hold_cnt.sv - loadable down-counter timing the CPU reset hold window
module riscv_loader_hold_cnt #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] count;

  // load on HOLD entry so the terminal count lands on the last HOLD cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(HOLD_CYCLES - 1);
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/riscv_mem_loader.sv
// rtl/riscv_mem_loader.sv - stream-to-memory preload controller holding the CPU in reset; optional RISCV_LOADER_CHECKSUM_EN
module riscv_mem_loader
  import riscv_loader_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_CH      = 2,
  parameter int LEN_W       = 16,
  parameter int HOLD_CYCLES = 4,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_start,
  input  logic [CH_W-1:0]      ld_ch,
  input  logic [ADDR_W-1:0]    ld_base,
  input  logic [LEN_W-1:0]     ld_len,
  riscv_mem_loader_if.slave    s,
  output logic [NUM_CH-1:0]    mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [DATA_W-1:0]    checksum
);

  state_t            state;
  logic              s_ready_q;
  logic [CH_W-1:0]   ch_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              accept;
  logic              last_word;
  logic              cmd_go;
  logic              cmd_legal;
  logic              hold_load;
  logic              hold_tc;

  assign s.ready   = s_ready_q;
  assign accept    = s.valid && s_ready_q;
  assign last_word = accept && (cnt_q == len_q - LEN_W'(1));
  assign cmd_go    = ld_start && ((state == IDLE) || (state == RUN));
  assign cmd_legal = (int'(ld_ch) < NUM_CH) && (ld_base[1:0] == 2'b00);
  assign hold_load = (cmd_go && cmd_legal && (ld_len == '0)) || last_word;

  riscv_loader_hold_cnt #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (hold_load),
    .en    (state == HOLD),
    .tc    (hold_tc)
  );

  // command decode, word write-out one cycle after accept, and IDLE/LOAD/HOLD/RUN sequencing
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      s_ready_q <= 1'b0;
      ch_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= '0;
      done   <= 1'b0;
      if (accept) begin
        mem_we    <= NUM_CH'(1) << ch_q;
        mem_addr  <= addr_q;
        mem_wdata <= s.data;
        addr_q    <= addr_q + ADDR_W'(WORD_BYTES);
        cnt_q     <= cnt_q + LEN_W'(1);
      end
      case (state)
        IDLE, RUN: begin
          if (ld_start) begin
            if (cmd_legal) begin
              err     <= 1'b0;
              ch_q    <= ld_ch;
              addr_q  <= ld_base;
              len_q   <= ld_len;
              cnt_q   <= '0;
              cpu_rst <= 1'b1;
              busy    <= 1'b1;
              if (ld_len != '0) begin
                state     <= LOAD;
                s_ready_q <= 1'b1;
              end else begin
                state <= HOLD;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (last_word) begin
            state     <= HOLD;
            s_ready_q <= 1'b0;
          end
        end
        HOLD: begin
          if (hold_tc) begin
            state   <= RUN;
            cpu_rst <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RISCV_LOADER_CHECKSUM_EN
  // running modular sum of written words, restarted by each accepted command
  always_ff @(posedge clk) begin
    if (!reset) begin
      checksum <= '0;
    end else if (cmd_go && cmd_legal) begin
      checksum <= '0;
    end else if (|mem_we) begin
      checksum <= checksum + mem_wdata;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_riscv_mem_loader.sv
// tb/tb_riscv_mem_loader.sv - directed self-checking bench for riscv_mem_loader
module tb_riscv_mem_loader;

  logic        clk;
  logic        reset;
  logic        ld_start;
  logic [0:0]  ld_ch;
  logic [31:0] ld_base;
  logic [15:0] ld_len;
  logic [1:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] checksum;

  logic        ld_start3;
  logic [1:0]  ld_ch3;
  logic [2:0]  mem_we3;
  logic [31:0] mem_addr3;
  logic [31:0] mem_wdata3;
  logic        cpu_rst3;
  logic        busy3;
  logic        done3;
  logic        err3;
  logic [31:0] checksum3;

  int n_chk;
  int n_pass;
  int wr_count;
  logic [0:0] cur_ch;

  riscv_mem_loader_if #(.DATA_W(32)) sif ();
  riscv_mem_loader_if #(.DATA_W(32)) sif3 ();

  riscv_mem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .ld_start  (ld_start),
    .ld_ch     (ld_ch),
    .ld_base   (ld_base),
    .ld_len    (ld_len),
    .s         (sif),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .checksum  (checksum)
  );

  riscv_mem_loader #(.NUM_CH(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .ld_start  (ld_start3),
    .ld_ch     (ld_ch3),
    .ld_base   (32'h0),
    .ld_len    (16'h0),
    .s         (sif3),
    .mem_we    (mem_we3),
    .mem_addr  (mem_addr3),
    .mem_wdata (mem_wdata3),
    .cpu_rst   (cpu_rst3),
    .busy      (busy3),
    .done      (done3),
    .err       (err3),
    .checksum  (checksum3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (|mem_we) wr_count++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_cpu_rst"}, 64'(cpu_rst), 64'd1);
    check({pfx, "_s_ready"}, 64'(sif.ready), 64'd0);
    check({pfx, "_mem_we"}, 64'(mem_we), 64'd0);
    check({pfx, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({pfx, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({pfx, "_busy"}, 64'(busy), 64'd0);
    check({pfx, "_done"}, 64'(done), 64'd0);
    check({pfx, "_err"}, 64'(err), 64'd0);
    check({pfx, "_checksum"}, 64'(checksum), 64'd0);
  endtask

  task automatic start(input logic [0:0] ch, input logic [31:0] base, input logic [15:0] len);
    ld_start = 1'b1;
    ld_ch    = ch;
    ld_base  = base;
    ld_len   = len;
    cur_ch   = ch;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] exp_addr);
    logic acc;
    int   n;
    n = 0;
    sif.valid = 1'b1;
    sif.data  = d;
    do begin
      acc = sif.ready;
      tick();
      n++;
    end while (!acc && n < 20);
    sif.valid = 1'b0;
    check("push_accepted", 64'(acc), 64'd1);
    check("wr_we", 64'(mem_we), 64'(2'b01 << cur_ch));
    check("wr_addr", 64'(mem_addr), 64'(exp_addr));
    check("wr_data", 64'(mem_wdata), 64'(d));
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("gap_no_we", 64'(mem_we), 64'd0);
    end
  endtask

  task automatic wait_done(input int exp);
    int n;
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    check("done_latency", 64'(n), 64'(exp));
    check("run_cpu_rst", 64'(cpu_rst), 64'd0);
    check("run_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int w0;
    n_chk = 0; n_pass = 0; wr_count = 0; cur_ch = '0;
    reset = 1'b0; ld_start = 1'b0; ld_ch = '0; ld_base = '0; ld_len = '0;
    ld_start3 = 1'b0; ld_ch3 = '0;
    sif.valid = 1'b0; sif.data = '0;
    sif3.valid = 1'b0; sif3.data = '0;
    repeat (3) tick();
    check_reset_vals("rst");
    reset = 1'b1;
    tick();

    // misaligned base: error, no state change
    w0 = wr_count;
    start(1'b0, 32'h13, 16'd2);
    check("bad_base_err", 64'(err), 64'd1);
    check("bad_base_ready", 64'(sif.ready), 64'd0);
    check("bad_base_busy", 64'(busy), 64'd0);
    check("bad_base_cpu_rst", 64'(cpu_rst), 64'd1);
    tick();
    check("bad_base_err_sticky", 64'(err), 64'd1);
    check("bad_base_no_wr", 64'(wr_count - w0), 64'd0);

    // out-of-range channel on a 3-channel loader, then a legal command clears err
    ld_start3 = 1'b1; ld_ch3 = 2'd3;
    tick();
    ld_start3 = 1'b0;
    check("bad_ch_err", 64'(err3), 64'd1);
    check("bad_ch_busy", 64'(busy3), 64'd0);
    check("bad_ch_we", 64'(mem_we3), 64'd0);
    ld_start3 = 1'b1; ld_ch3 = 2'd2;
    tick();
    ld_start3 = 1'b0;
    check("ch2_err_clr", 64'(err3), 64'd0);
    check("ch2_busy", 64'(busy3), 64'd1);

    // back-to-back load of three words into data memory
    w0 = wr_count;
    start(1'b1, 32'h10, 16'd3);
    check("t1_err_clr", 64'(err), 64'd0);
    check("t1_ready", 64'(sif.ready), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    push(32'hAAAA_0001, 32'h10);
    push(32'hBBBB_0002, 32'h14);
    push(32'hCCCC_0003, 32'h18);
    check("t1_ready_drop", 64'(sif.ready), 64'd0);
    check("t1_hold_cpu_rst", 64'(cpu_rst), 64'd1);
    wait_done(4);
    tick();
    check("t1_done_pulse", 64'(done), 64'd0);
    check("t1_writes", 64'(wr_count - w0), 64'd3);

    // reload from RUN with valid gaps
    w0 = wr_count;
    start(1'b1, 32'h100, 16'd3);
    check("t2_reload_cpu_rst", 64'(cpu_rst), 64'd1);
    push(32'h1111_1111, 32'h100);
    gap(2);
    push(32'h2222_2222, 32'h104);
    push(32'h3333_3333, 32'h108);
    wait_done(4);
    check("t2_writes", 64'(wr_count - w0), 64'd3);

    // zero-length command goes straight to HOLD
    w0 = wr_count;
    start(1'b0, 32'h40, 16'd0);
    check("t4_busy", 64'(busy), 64'd1);
    check("t4_ready", 64'(sif.ready), 64'd0);
    wait_done(4);
    check("t4_writes", 64'(wr_count - w0), 64'd0);

    // address wrap at the top of the space
    w0 = wr_count;
    start(1'b0, 32'hFFFF_FFFC, 16'd2);
    push(32'h5555_AAAA, 32'hFFFF_FFFC);
    push(32'hAAAA_5555, 32'h0);
    wait_done(4);
    check("t4_wrap_writes", 64'(wr_count - w0), 64'd2);

    // checksum of 0xFFFFFFFF + 0x2
    start(1'b0, 32'h0, 16'd2);
    push(32'hFFFF_FFFF, 32'h0);
    push(32'h0000_0002, 32'h4);
    wait_done(4);
`ifdef RISCV_LOADER_CHECKSUM_EN
    check("t6_checksum", 64'(checksum), 64'h1);
`else
    check("t6_checksum", 64'(checksum), 64'h0);
`endif

    // reset in the middle of a load abandons it
    start(1'b1, 32'h200, 16'd4);
    push(32'hDEAD_BEEF, 32'h200);
    reset = 1'b0;
    tick();
    check_reset_vals("midrst");
    reset = 1'b1;
    w0 = wr_count;
    sif.valid = 1'b1;
    sif.data  = 32'h1234_5678;
    repeat (3) tick();
    check("midrst_ready", 64'(sif.ready), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_no_wr", 64'(wr_count - w0), 64'd0);
    sif.valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
